// File: rtl/nibble_word_assembler.sv
// nibble_word_assembler
//   Collects NIBBLES consecutive sum nibbles from the 4-bit registered adder,
//   least-significant first, and presents them as one wide word over a
//   valid/ready handshake. Runs at one nibble per clock. A completed word
//   can load into the output register in the same cycle the previous word
//   is drained.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset; overrides everything else
//   flush      drops the partially assembled word (output register untouched)
//   in_valid   sum/carry hold a nibble this cycle
//   in_ready   nibble accepted when in_valid && in_ready
//   sum        adder sum nibble
//   carry      adder carry that goes with sum
//   out_valid  out_word/out_carry/out_ovf hold a completed word
//   out_ready  consumer takes the word when out_valid && out_ready
//   out_word   assembled word, nibble k at bits [4k+3:4k]
//   out_carry  carry of the most-significant nibble
//   out_ovf    OR of the carries of nibbles 0..NIBBLES-2
//   busy       a partial word is held
module nibble_word_assembler #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             sum,
    input  logic                   carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_word,
    output logic                   out_carry,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    logic [IW-1:0]  idx_q,   idx_d;
    logic [W-5:0]   asm_q,   asm_d;
    logic           ovf_q,   ovf_d;
    logic           oval_q,  oval_d;
    logic [W-1:0]   oword_q, oword_d;
    logic           ocar_q,  ocar_d;
    logic           oovf_q,  oovf_d;

    logic last;
    logic accept;
    logic complete;

    assign last     = (idx_q == LAST_IDX);
    // Only the completing nibble needs a free output slot; earlier nibbles
    // go into the assembly register regardless of the pending output.
    assign in_ready = !flush && !(last && oval_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && last;

    // Assembly side: index, partial word and sticky carry.
    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        ovf_d = ovf_q;
        if (flush || complete) begin
            idx_d = '0;
            asm_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            for (int unsigned k = 0; k < NIBBLES - 1; k++) begin
                if (idx_q == IW'(k)) begin
                    asm_d[4*k +: 4] = sum;
                end
            end
            ovf_d = ovf_q | carry;
            idx_d = idx_q + 1'b1;
        end
    end

    // Output side: a completion loads the register even when the previous
    // word is drained in the same cycle, so out_valid stays high.
    always_comb begin
        oval_d  = oval_q;
        oword_d = oword_q;
        ocar_d  = ocar_q;
        oovf_d  = oovf_q;
        if (complete) begin
            oval_d  = 1'b1;
            oword_d = {sum, asm_q};
            ocar_d  = carry;
            oovf_d  = ovf_q;
        end else if (oval_q && out_ready) begin
            oval_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
            oval_q  <= 1'b0;
            oword_q <= '0;
            ocar_q  <= 1'b0;
            oovf_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
            oval_q  <= oval_d;
            oword_q <= oword_d;
            ocar_q  <= ocar_d;
            oovf_q  <= oovf_d;
        end
    end

    assign out_valid = oval_q;
    assign out_word  = oword_q;
    assign out_carry = ocar_q;
    assign out_ovf   = oovf_q;
    assign busy      = (idx_q != '0);

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Bench for nibble_word_assembler with NIBBLES=4.
module tb_nibble_word_assembler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, carry;
    logic [3:0]  sum;
    logic        out_valid, out_ready, out_carry, out_ovf, busy;
    logic [15:0] out_word;

    nibble_word_assembler #(.NIBBLES(N)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .carry(carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_carry(out_carry), .out_ovf(out_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model: list of accepted nibbles plus one output slot.
    logic [4:0]  mq[$];
    logic        m_pend;
    logic [15:0] m_word;
    logic        m_car, m_ovf;
    logic        last_ir;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] dut_pack();
        return {out_valid, out_word, out_carry, out_ovf, busy};
    endfunction

    function automatic logic [19:0] model_pack();
        return {m_pend, m_word, m_car, m_ovf, (mq.size() != 0)};
    endfunction

    task automatic step(input logic iv, input logic [3:0] s, input logic c,
                        input logic ordy, input logic fl, input logic rst);
        logic m_ir, done;
        logic [15:0] w;
        logic o;
        @(negedge clk);
        in_valid = iv; sum = s; carry = c; out_ready = ordy; flush = fl; reset = rst;
        #1;
        m_ir = !fl && !((mq.size() == N - 1) && m_pend && !ordy);
        last_ir = in_ready;
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, m_ir});
        @(posedge clk);
        done = 1'b0;
        if (rst) begin
            mq.delete();
            m_pend = 1'b0; m_word = '0; m_car = 1'b0; m_ovf = 1'b0;
        end else begin
            if (fl) mq.delete();
            else if (iv && m_ir) begin
                mq.push_back({c, s});
                if (mq.size() == N) begin
                    w = '0; o = 1'b0;
                    for (int k = 0; k < N; k++) w = w | (16'(mq[k][3:0]) << (4 * k));
                    for (int k = 0; k < N - 1; k++) o = o | mq[k][4];
                    m_word = w; m_car = mq[N-1][4]; m_ovf = o;
                    m_pend = 1'b1; done = 1'b1;
                    mq.delete();
                end
            end
            if (!done && m_pend && ordy) m_pend = 1'b0;
        end
        #1;
        chk("model_outputs", {12'd0, dut_pack()}, {12'd0, model_pack()});
    endtask

    typedef struct {
        logic iv; logic [3:0] s; logic c; logic ordy; logic fl;
        logic e_ir; logic e_ov; logic [15:0] e_w; logic e_c; logic e_o; logic e_b;
    } vec_t;

    vec_t tv[13];

    initial begin
        tv[0]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tv[3]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4321, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b0, 1'b0, 1'b1};
        tv[5]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b0, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 4'hD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hDCBA, 1'b1, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hDCBA, 1'b1, 1'b1, 1'b1};
        tv[9]  = '{1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hDCBA, 1'b1, 1'b1, 1'b1};
        tv[10] = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hDCBA, 1'b1, 1'b1, 1'b1};
        tv[11] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8765, 1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8765, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; sum = '0; carry = 1'b0; out_ready = 1'b0;
        m_pend = 1'b0; m_word = '0; m_car = 1'b0; m_ovf = 1'b0;

        // Reset state
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_state", {12'd0, dut_pack()}, 32'd0);

        // Basic word, carries / sticky ovf, sticky clear
        for (int i = 0; i < 13; i++) begin
            step(tv[i].iv, tv[i].s, tv[i].c, tv[i].ordy, tv[i].fl, 1'b0);
            chk($sformatf("table_ir[%0d]", i), {31'd0, last_ir}, {31'd0, tv[i].e_ir});
            chk($sformatf("table_out[%0d]", i), {12'd0, dut_pack()},
                {12'd0, tv[i].e_ov, tv[i].e_w, tv[i].e_c, tv[i].e_o, tv[i].e_b});
        end

        // Backpressure: first word held, only the 8th nibble stalls
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("bp_ir[%0d]", i), {31'd0, last_ir}, 32'd1);
            if (i >= 4) chk($sformatf("bp_hold[%0d]", i), {15'd0, out_valid, out_word}, {15'd0, 1'b1, 16'h4321});
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bp_stall_ir", {31'd0, last_ir}, 32'd0);
            chk("bp_stall_hold", {15'd0, out_valid, out_word}, {15'd0, 1'b1, 16'h4321});
        end
        step(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_release_ir", {31'd0, last_ir}, 32'd1);
        chk("bp_second_word", {15'd0, out_valid, out_word}, {15'd0, 1'b1, 16'h8765});
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush after two nibbles drops the concurrent nibble
        step(1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_ir", {31'd0, last_ir}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        step(1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_clean_word", {13'd0, out_valid, out_word, out_carry, out_ovf},
            {13'd0, 1'b1, 16'hEDCB, 1'b0, 1'b0});
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Continuous stream: 100 words, out_valid every 4th cycle
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            chk("stream_valid_phase", {31'd0, out_valid}, {31'd0, ((i % 4) == 3)});
        end

        // Random handshake, flush and backpressure
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset with a pending output and three nibbles in progress
        for (int i = 1; i <= 7; i++) step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_pending", {30'd0, out_valid, busy}, 32'd3);
        step(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_mid_run", {12'd0, dut_pack()}, 32'd0);
        step(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_reset_word", {13'd0, out_valid, out_word, out_carry, out_ovf},
            {13'd0, 1'b1, 16'h6789, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
